// File: rtl/wl_pulse_pkg.sv
// Shared constants and state encoding for the wordline pulse controller.
package wl_pulse_pkg;

    localparam int unsigned N_LINES = 16;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRECH = 2'd1,
        PULSE = 2'd2
    } state_e;

endpackage

// File: rtl/onehot_chk.sv
// One-hot detector for a sampled predecoder pattern.
// Only built when WL_PULSE_ONEHOT_CHECK_EN is defined.
`ifdef WL_PULSE_ONEHOT_CHECK_EN
module onehot_chk
    import wl_pulse_pkg::*;
(
    input  logic [N_LINES-1:0] sel,
    output logic               is_onehot
);

    // A nonzero value with its lowest set bit cleared is zero only if exactly one bit was set.
    always_comb begin
        is_onehot = (sel != '0) && ((sel & (sel - N_LINES'(1))) == '0);
    end

endmodule
`endif

// File: rtl/wl_pulse_ctrl.sv
// Latches one predecoded row per handshake and drives a clean fixed-width wordline pulse
// followed by a precharge gap. Define WL_PULSE_ONEHOT_CHECK_EN to reject non-one-hot samples.
module wl_pulse_ctrl
    import wl_pulse_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned PRECH_W = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [N_LINES-1:0] predec_n,
    output logic [N_LINES-1:0] wl_en,
    output logic               done,
    output logic               err_onehot
);

    state_e             state_q, state_d;
    logic [N_LINES-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_LINES-1:0] wl_en_q, wl_en_d;
    logic               done_q, done_d;
    logic [N_LINES-1:0] sel_in;
    logic               accept;
    logic               sel_ok;

    assign sel_in    = ~predec_n;
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

`ifdef WL_PULSE_ONEHOT_CHECK_EN
    logic err_q, err_d;

    onehot_chk u_onehot_chk (
        .sel       (sel_in),
        .is_onehot (sel_ok)
    );

    always_comb begin
        err_d = accept && !sel_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_onehot = err_q;
`else
    assign sel_ok     = 1'b1;
    assign err_onehot = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            wl_en_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            wl_en_q <= wl_en_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        wl_en_d = wl_en_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sel_d = sel_in;
                    if (sel_ok) begin
                        state_d = PULSE;
                        wl_en_d = sel_in;
                        cnt_d   = CNT_W'(PULSE_W - 1);
                    end
                end
            end
            PULSE: begin
                wl_en_d = sel_q;
                if (cnt_q == '0) begin
                    state_d = PRECH;
                    wl_en_d = '0;
                    cnt_d   = CNT_W'(PRECH_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PRECH: begin
                wl_en_d = '0;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                wl_en_d = '0;
            end
        endcase

        // Registered done must coincide with the final precharge cycle, so look at the next state.
        done_d = (state_d == PRECH) && (cnt_d == '0);
    end

    assign wl_en = wl_en_q;
    assign done  = done_q;

    assert property (@(posedge clk) (PULSE_W != 0) && (PRECH_W != 0));

endmodule
